// File: rtl/d7s_scan_capture.sv
// Receive end of a multiplexed 3-digit 7-segment bus. Each digit is captured
// once its segment and select lines have been stable long enough, then
// decoded back to BCD. A frame pulse fires once all three digits are captured.
module d7s_scan_capture #(
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg,
    input  logic [2:0]       sel,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [11:0]      value_bcd,
    output logic [2:0]       blank,
    output logic             frame_valid,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [3:0] CNT_MAX = 4'(SETTLE_CYC);
    localparam logic [3:0] CNT_CAP = 4'(SETTLE_CYC - 1);

    logic [6:0] s_seg, p_seg;
    logic [2:0] s_sel, p_sel;
    logic [3:0] cnt;
    logic [1:0] state, state_next;
    logic [2:0] mask;

    logic       change;
    logic       capture;
    logic       multi_hot;
    logic [3:0] dec_val;
    logic       dec_ok;
    logic       dec_blank;
    logic [2:0] mask_next;

    assign change    = (s_seg != p_seg) || (s_sel != p_sel);
    assign capture   = (state == ST_SETTLE) && !change && (cnt == CNT_CAP);
    assign multi_hot = (s_sel[0] & s_sel[1]) | (s_sel[0] & s_sel[2]) | (s_sel[1] & s_sel[2]);
    assign mask_next = mask | s_sel;
    assign value_bcd = {digit2, digit1, digit0};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_val   = 4'hF;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (s_seg)
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            7'h00:   dec_blank = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (change) begin
            state_next = (s_sel == 3'b000) ? ST_WAIT : ST_SETTLE;
        end else if (capture) begin
            state_next = ST_HOLD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg <= '0;
            s_sel <= '0;
            p_seg <= '0;
            p_sel <= '0;
            cnt   <= '0;
            state <= ST_WAIT;
        end else begin
            s_seg <= seg;
            s_sel <= sel;
            p_seg <= s_seg;
            p_sel <= s_sel;
            state <= state_next;
            if (change) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit0      <= '0;
            digit1      <= '0;
            digit2      <= '0;
            blank       <= '0;
            mask        <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            if (capture) begin
                if (multi_hot || !dec_ok) begin
                    err_pulse <= 1'b1;
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_count <= err_count + 1'b1;
                    end
                end else begin
                    if (s_sel[0]) digit0 <= dec_val;
                    if (s_sel[1]) digit1 <= dec_val;
                    if (s_sel[2]) digit2 <= dec_val;
                    blank <= (blank & ~s_sel) | (dec_blank ? s_sel : 3'b000);
                    // Completion clears the mask on the same edge the last digit lands.
                    if (mask_next == 3'b111) begin
                        mask        <= 3'b000;
                        frame_valid <= 1'b1;
                    end else begin
                        mask <= mask_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_d7s_scan_capture.sv
// Bench for d7s_scan_capture: a pin-history model predicts every output each
// cycle, and directed scans pin key values with literal expectations.
module tb_d7s_scan_capture;

    localparam int SETTLE_CYC = 4;
    localparam int ERR_W      = 8;
    localparam int ERR_SAT    = (1 << ERR_W) - 1;

    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       seg = '0;
    logic [2:0]       sel = '0;
    logic [3:0]       digit0, digit1, digit2;
    logic [11:0]      value_bcd;
    logic [2:0]       blank;
    logic             frame_valid, err_pulse;
    logic [ERR_W-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int dut_frames = 0;
    int dut_errs   = 0;
    bit cmp_on = 1'b0;

    d7s_scan_capture #(.SETTLE_CYC(SETTLE_CYC), .ERR_W(ERR_W)) u_dut (
        .clk(clk), .rst(rst), .seg(seg), .sel(sel),
        .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .value_bcd(value_bcd), .blank(blank),
        .frame_valid(frame_valid), .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns 0..9 for a digit, 15 for all-off, -1 for an unknown pattern.
    function automatic int seg_to_val(input logic [6:0] p);
        if (p == 7'h00) return 15;
        for (int i = 0; i < 10; i++) begin
            if (SEG_TBL[i] == p) return i;
        end
        return -1;
    endfunction

    // Model: a capture happens when the pins have been identical for exactly
    // SETTLE_CYC+1 consecutive samples with a nonzero select; it shows one edge later.
    logic [6:0] m_last_seg, m_pseg;
    logic [2:0] m_last_sel, m_psel;
    int         m_run;
    bit         m_pend;
    logic [3:0] m_dig [3];
    logic [2:0] m_blank, m_mask;
    logic       m_frame, m_err;
    int         m_errc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last_seg = '0; m_last_sel = '0; m_run = 0; m_pend = 0;
            m_pseg = '0; m_psel = '0;
            for (int i = 0; i < 3; i++) m_dig[i] = '0;
            m_blank = '0; m_mask = '0; m_frame = 0; m_err = 0; m_errc = 0;
        end else begin
            m_frame = 0;
            m_err   = 0;
            if (m_pend) begin
                int code;
                int idx;
                code = seg_to_val(m_pseg);
                if ($countones(m_psel) >= 2 || code < 0) begin
                    m_err = 1;
                    if (m_errc < ERR_SAT) m_errc++;
                end else begin
                    idx = m_psel[0] ? 0 : (m_psel[1] ? 1 : 2);
                    m_dig[idx]   = 4'(code);
                    m_blank[idx] = (code == 15);
                    m_mask[idx]  = 1'b1;
                    if (m_mask == 3'b111) begin
                        m_frame = 1;
                        m_mask  = '0;
                    end
                end
            end
            if (seg == m_last_seg && sel == m_last_sel) m_run++;
            else m_run = 1;
            m_last_seg = seg;
            m_last_sel = sel;
            m_pend = (m_run == SETTLE_CYC + 1) && (sel != 3'b000);
            m_pseg = seg;
            m_psel = sel;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            check("digit0", 32'(digit0), 32'(m_dig[0]));
            check("digit1", 32'(digit1), 32'(m_dig[1]));
            check("digit2", 32'(digit2), 32'(m_dig[2]));
            check("value_bcd", 32'(value_bcd), 32'({m_dig[2], m_dig[1], m_dig[0]}));
            check("blank", 32'(blank), 32'(m_blank));
            check("frame_valid", 32'(frame_valid), 32'(m_frame));
            check("err_pulse", 32'(err_pulse), 32'(m_err));
            check("err_count", 32'(err_count), 32'(m_errc));
            if (frame_valid) dut_frames++;
            if (err_pulse) dut_errs++;
        end
    end

    task automatic drive(input logic [2:0] sl, input logic [6:0] sg, input int n);
        @(negedge clk);
        sel = sl;
        seg = sg;
        repeat (n) @(posedge clk);
    endtask

    int f_base, e_base;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_on = 1'b1;

        // Idle after reset
        drive(3'b000, 7'h00, 20);
        #1;
        check("idle value_bcd", 32'(value_bcd), 32'h000);
        check("idle err_count", 32'(err_count), 32'd0);
        check("idle blank", 32'(blank), 32'd0);
        check("idle pulses", 32'(dut_frames + dut_errs), 32'd0);

        // Scan 1,2,3 with latency and frame-alignment checks
        f_base = dut_frames;
        drive(3'b001, 7'h06, 5);
        #1 check("latency digit0 early", 32'(digit0), 32'd0);
        @(posedge clk);
        #1 check("latency digit0 on time", 32'(digit0), 32'd1);
        repeat (2) @(posedge clk);
        drive(3'b010, 7'h5B, 8);
        drive(3'b100, 7'h4F, 5);
        #1 check("frame before digit2", 32'(frame_valid), 32'd0);
        @(posedge clk);
        #1;
        check("frame with digit2", 32'(frame_valid), 32'd1);
        check("digit2 with frame", 32'(digit2), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        check("scan value_bcd", 32'(value_bcd), 32'h321);
        check("scan frame count", 32'(dut_frames - f_base), 32'd1);

        // Segment toggling faster than the settle window
        e_base = dut_errs;
        for (int i = 0; i < 4; i++) begin
            drive(3'b001, 7'h3F, 3);
            drive(3'b001, 7'h06, 3);
        end
        #1;
        check("toggle digit0", 32'(digit0), 32'd1);
        check("toggle errs", 32'(dut_errs - e_base), 32'd0);

        // Invalid pattern, then saturation of the error counter
        e_base = dut_errs;
        drive(3'b010, 7'h7E, 8);
        #1;
        check("bad err_count", 32'(err_count), 32'd1);
        check("bad err pulses", 32'(dut_errs - e_base), 32'd1);
        check("bad digit1", 32'(digit1), 32'd2);
        for (int i = 0; i < 256; i++) begin
            drive(3'b000, 7'h00, 2);
            drive(3'b010, 7'h7E, 8);
        end
        #1;
        check("sat err_count", 32'(err_count), 32'(ERR_SAT));
        check("sat err pulses", 32'(dut_errs - e_base), 32'd257);

        // Multi-hot select, then a blank digit
        e_base = dut_errs;
        drive(3'b011, 7'h3F, 8);
        #1;
        check("multihot err", 32'(dut_errs - e_base), 32'd1);
        check("multihot value", 32'(value_bcd), 32'h321);
        drive(3'b100, 7'h00, 8);
        #1;
        check("blank digit2", 32'(digit2), 32'hF);
        check("blank flags", 32'(blank), 32'b100);

        // Reset mid-settle of the third digit, then a clean 7,8,9 scan
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(3'b001, 7'h6D, 8);
        drive(3'b010, 7'h66, 8);
        drive(3'b100, 7'h7F, 2);
        @(negedge clk);
        rst = 1'b1;
        sel = 3'b000;
        seg = 7'h00;
        @(posedge clk);
        #1;
        check("rst value_bcd", 32'(value_bcd), 32'h000);
        check("rst err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        f_base = dut_frames;
        drive(3'b000, 7'h00, 3);
        drive(3'b001, 7'h07, 8);
        drive(3'b010, 7'h7F, 8);
        drive(3'b100, 7'h6F, 8);
        #1;
        check("final value_bcd", 32'(value_bcd), 32'h987);
        check("final frame count", 32'(dut_frames - f_base), 32'd1);
        check("final blank", 32'(blank), 32'd0);

        drive(3'b000, 7'h00, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
